// File: rtl/sin_sequencer.sv
// Sine-table read sequencer: issues bursts of phase-stepped table reads and forwards the returned samples.
// Optional build macro SIN_SEQ_HOLD_EN adds a hold input that pauses reads while running.
module sin_sequencer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
`ifdef SIN_SEQ_HOLD_EN
   input  logic              hold,
`endif
   input  logic [ADDR_W-1:0] phase_inc,
   input  logic [ADDR_W-1:0] burst_len,
   output logic              tbl_rd,
   output logic [ADDR_W-1:0] tbl_addr,
   input  logic [DATA_W-1:0] tbl_dout,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state_r, state_s;
   logic [ADDR_W-1:0] phase_r, phase_s;
   logic [ADDR_W-1:0] count_r, count_s;
   logic [ADDR_W-1:0] inc_r, inc_s;
   logic [ADDR_W-1:0] len_r, len_s;
   logic [ADDR_W-1:0] addr_s;
   logic              rd_s;
   logic              done_s;
   logic              hold_s;

`ifdef SIN_SEQ_HOLD_EN
   assign hold_s = hold;
`else
   assign hold_s = 1'b0;
`endif

   assign sample = tbl_dout;

   // Next-state and next-output logic; phase_r always holds the address of the next read.
   always_comb begin
      state_s = state_r;
      phase_s = phase_r;
      count_s = count_r;
      inc_s   = inc_r;
      len_s   = len_r;
      addr_s  = tbl_addr;
      rd_s    = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start && !stop) begin
               state_s = RUN;
               inc_s   = phase_inc;
               len_s   = burst_len;
               rd_s    = 1'b1;
               addr_s  = ZERO;
               phase_s = phase_inc;
               count_s = ONE;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (stop || ((len_r != ZERO) && (count_r == len_r))) begin
               state_s = DRAIN;
               done_s  = 1'b1;
            end else if (hold_s) begin
               state_s = RUN;
            end else begin
               rd_s    = 1'b1;
               addr_s  = phase_r;
               phase_s = phase_r + inc_r;
               count_s = count_r + ONE;
            end
         end
         DRAIN: begin
            state_s = IDLE;
            phase_s = ZERO;
            count_s = ZERO;
         end
         default: begin
            state_s = IDLE;
            phase_s = ZERO;
            count_s = ZERO;
         end
      endcase
   end

   // State and registered-output update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         phase_r      <= ZERO;
         count_r      <= ZERO;
         inc_r        <= ZERO;
         len_r        <= ZERO;
         tbl_rd       <= 1'b0;
         tbl_addr     <= ZERO;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_r      <= state_s;
         phase_r      <= phase_s;
         count_r      <= count_s;
         inc_r        <= inc_s;
         len_r        <= len_s;
         tbl_rd       <= rd_s;
         tbl_addr     <= addr_s;
         sample_valid <= tbl_rd;
         busy         <= (state_s != IDLE);
         done         <= done_s;
      end
   end

endmodule

// File: tb/tb_sin_sequencer.sv
// Directed scoreboard bench for sin_sequencer; expected read addresses and samples are queued as stimulus is driven.
module tb_sin_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop;
   logic       hold;
   logic [7:0] phase_inc, burst_len;
   logic       tbl_rd;
   logic [7:0] tbl_addr;
   logic [7:0] tbl_dout;
   logic [7:0] sample;
   logic       sample_valid, busy, done;

   int compared   = 0;
   int mismatched = 0;
   int done_cnt, busy_cnt, rd_cnt, valid_cnt;

   logic [7:0] exp_rd_q[$];
   logic [7:0] exp_smp_q[$];

   always #5 clk = ~clk;

   sin_sequencer #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .stop         (stop),
`ifdef SIN_SEQ_HOLD_EN
      .hold         (hold),
`endif
      .phase_inc    (phase_inc),
      .burst_len    (burst_len),
      .tbl_rd       (tbl_rd),
      .tbl_addr     (tbl_addr),
      .tbl_dout     (tbl_dout),
      .sample       (sample),
      .sample_valid (sample_valid),
      .busy         (busy),
      .done         (done)
   );

   function automatic logic [7:0] sine_of(input logic [7:0] a);
      return (a * 8'd3) + 8'd7;
   endfunction

   // Synchronous table model: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (tbl_rd) tbl_dout <= sine_of(tbl_addr);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_rd(input logic [7:0] a);
      exp_rd_q.push_back(a);
      exp_smp_q.push_back(sine_of(a));
   endtask

   task automatic clear_counts();
      done_cnt = 0; busy_cnt = 0; rd_cnt = 0; valid_cnt = 0;
   endtask

   // Output monitor: pops expected reads and samples as the DUT produces them.
   always @(negedge clk) begin
      if (tbl_rd) begin
         rd_cnt++;
         check("rd_expected", (exp_rd_q.size() != 0), 1);
         if (exp_rd_q.size() != 0) check("tbl_addr", tbl_addr, exp_rd_q.pop_front());
      end
      if (sample_valid) begin
         valid_cnt++;
         check("smp_expected", (exp_smp_q.size() != 0), 1);
         if (exp_smp_q.size() != 0) check("sample", sample, exp_smp_q.pop_front());
      end
      if (done) begin
         done_cnt++;
         check("done_with_valid", sample_valid, 1);
      end
      if (busy) busy_cnt++;
   end

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check({tag, "_idle"}, busy, 0);
      @(negedge clk);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
      phase_inc = 8'd0; burst_len = 8'd0;
      tbl_dout = 8'd0;
      clear_counts();
      #2;
      check("rst_tbl_rd", tbl_rd, 0);
      check("rst_tbl_addr", tbl_addr, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      step(); step();
      rst_n = 1'b1;
      step();

      // Basic burst, step 1, length 4
      clear_counts();
      phase_inc = 8'd1; burst_len = 8'd4; start = 1'b1;
      for (int a = 0; a < 4; a++) push_rd(8'(a));
      step();
      start = 1'b0;
      wait_idle("b1");
      check("b1_done_cnt", done_cnt, 1);
      check("b1_busy_cnt", busy_cnt, 5);
      check("b1_valid_cnt", valid_cnt, 4);
      check("b1_rd_cnt", rd_cnt, 4);

      // Phase wrap, step 100
      clear_counts();
      phase_inc = 8'd100; burst_len = 8'd4; start = 1'b1;
      push_rd(8'd0); push_rd(8'd100); push_rd(8'd200); push_rd(8'd44);
      step();
      start = 1'b0;
      wait_idle("b2");
      check("b2_done_cnt", done_cnt, 1);
      check("b2_valid_cnt", valid_cnt, 4);

      // Continuous run, stopped after six reads; restart attempt mid-run is ignored
      clear_counts();
      phase_inc = 8'd64; burst_len = 8'd0; start = 1'b1;
      push_rd(8'd0); push_rd(8'd64); push_rd(8'd128);
      push_rd(8'd192); push_rd(8'd0); push_rd(8'd64);
      step();
      start = 1'b0;
      step();
      start = 1'b1; phase_inc = 8'd5; burst_len = 8'd2;
      step();
      start = 1'b0;
      step(); step(); step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_idle("b3");
      check("b3_rd_cnt", rd_cnt, 6);
      check("b3_done_cnt", done_cnt, 1);
      check("b3_busy_cnt", busy_cnt, 7);

      // Start and stop together in IDLE
      clear_counts();
      phase_inc = 8'd1; burst_len = 8'd4; start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      step(); step();
      check("ss_busy_cnt", busy_cnt, 0);
      check("ss_rd_cnt", rd_cnt, 0);

      // Reset during the third read of an 8-sample burst
      clear_counts();
      phase_inc = 8'd1; burst_len = 8'd8; start = 1'b1;
      exp_rd_q.push_back(8'd0); exp_rd_q.push_back(8'd1);
      exp_smp_q.push_back(sine_of(8'd0));
      step();
      start = 1'b0;
      step();
      step();
      check("rst3_tbl_rd", tbl_rd, 1);
      check("rst3_tbl_addr", tbl_addr, 2);
      rst_n = 1'b0;
      #1;
      check("rst3_tbl_rd0", tbl_rd, 0);
      check("rst3_addr0", tbl_addr, 0);
      check("rst3_valid0", sample_valid, 0);
      check("rst3_busy0", busy, 0);
      check("rst3_done0", done, 0);
      step();
      rst_n = 1'b1;
      check("rst3_no_done", done_cnt, 0);
      step();
      clear_counts();
      phase_inc = 8'd3; burst_len = 8'd2; start = 1'b1;
      push_rd(8'd0); push_rd(8'd3);
      step();
      start = 1'b0;
      wait_idle("b5");
      check("b5_done_cnt", done_cnt, 1);
      check("b5_rd_cnt", rd_cnt, 2);

`ifdef SIN_SEQ_HOLD_EN
      // Hold for two cycles after the first read
      clear_counts();
      phase_inc = 8'd1; burst_len = 8'd3; start = 1'b1;
      push_rd(8'd0); push_rd(8'd1); push_rd(8'd2);
      step();
      start = 1'b0; hold = 1'b1;
      step(); step();
      hold = 1'b0;
      wait_idle("hold");
      check("hold_rd_cnt", rd_cnt, 3);
      check("hold_done_cnt", done_cnt, 1);
      check("hold_busy_cnt", busy_cnt, 6);
`endif

      check("rd_q_drained", exp_rd_q.size(), 0);
      check("smp_q_drained", exp_smp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
